// File: rtl/sequencer_pkg.sv
// Shared definitions for the microprogram sequencer: default address width
// and the 4-bit sequencer instruction encoding.
package sequencer_pkg;

    localparam int ADDR_W_DEF = 8;

    typedef enum logic [3:0] {
        I_JZ   = 4'd0,
        I_CJS  = 4'd1,
        I_JMAP = 4'd2,
        I_CJP  = 4'd3,
        I_PUSH = 4'd4,
        I_JSRP = 4'd5,
        I_CJV  = 4'd6,
        I_JRP  = 4'd7,
        I_RFCT = 4'd8,
        I_RPCT = 4'd9,
        I_CRTN = 4'd10,
        I_CJPP = 4'd11,
        I_LDCT = 4'd12,
        I_LOOP = 4'd13,
        I_CONT = 4'd14,
        I_TWB  = 4'd15
    } instr_e;

endpackage

// File: rtl/mps_stack.sv
// Subroutine/loop LIFO: a push when full overwrites the top entry, a pop when
// empty is ignored, and clear empties the stack without touching storage.
module mps_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] data_i,
    output logic [ADDR_W-1:0] tos_o,
    output logic              full_n_o
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              full, empty;
    logic [IDX_W-1:0]  wr_idx, top_idx;

    assign full     = (sp_q == SP_MAX);
    assign empty    = (sp_q == '0);
    assign full_n_o = ~full;
    assign top_idx  = IDX_W'(sp_q - SP_W'(1));
    // When full, the write lands on the current top instead of past the end.
    assign wr_idx   = full ? IDX_W'(STACK_DEPTH - 1) : IDX_W'(sp_q);
    assign tos_o    = empty ? '0 : mem_q[top_idx];

    always_comb begin
        sp_d = sp_q;
        if (clr_i)
            sp_d = '0;
        else if (push_i && !full)
            sp_d = sp_q + SP_W'(1);
        else if (pop_i && !empty)
            sp_d = sp_q - SP_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sp_q <= '0;
            for (int k = 0; k < STACK_DEPTH; k++)
                mem_q[k] <= '0;
        end else begin
            sp_q <= sp_d;
            if (push_i && !clr_i)
                mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/microprogram_sequencer.sv
// 2910-style microprogram sequencer: selects the next microaddress Y from
// uPC, D, the loop counter R or the stack top, per the 16 instructions.
module microprogram_sequencer
    import sequencer_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int STACK_DEPTH = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [3:0]        I,
    input  logic              CC_N,
    input  logic              CCEN_N,
    input  logic              CI,
    input  logic              RLD_N,
    input  logic [ADDR_W-1:0] D,
    output logic [ADDR_W-1:0] Y,
    output logic              FULL_N,
    output logic              PL_N,
    output logic              MAP_N,
    output logic              VECT_N
);

    instr_e            instr;
    logic              pass, r_zero;
    logic [ADDR_W-1:0] upc_q, upc_d;
    logic [ADDR_W-1:0] r_q, r_d;
    logic [ADDR_W-1:0] tos;
    logic              stk_push, stk_pop, stk_clr;
    logic              r_load, r_dec;

    assign instr  = instr_e'(I);
    assign pass   = CCEN_N | ~CC_N;
    assign r_zero = (r_q == '0);

    assign MAP_N  = (instr != I_JMAP);
    assign VECT_N = (instr != I_CJV);
    assign PL_N   = (instr == I_JMAP) || (instr == I_CJV);

    always_comb begin
        Y        = upc_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_clr  = 1'b0;
        r_load   = 1'b0;
        r_dec    = 1'b0;
        unique case (instr)
            I_JZ:   begin Y = '0; stk_clr = 1'b1; end
            I_CJS:  if (pass) begin Y = D; stk_push = 1'b1; end
            I_JMAP: Y = D;
            I_CJP:  if (pass) Y = D;
            I_PUSH: begin stk_push = 1'b1; r_load = pass; end
            I_JSRP: begin Y = pass ? D : r_q; stk_push = 1'b1; end
            I_CJV:  if (pass) Y = D;
            I_JRP:  Y = pass ? D : r_q;
            I_RFCT: if (!r_zero) begin Y = tos; r_dec = 1'b1; end
                    else stk_pop = 1'b1;
            I_RPCT: if (!r_zero) begin Y = D; r_dec = 1'b1; end
            I_CRTN: if (pass) begin Y = tos; stk_pop = 1'b1; end
            I_CJPP: if (pass) begin Y = D; stk_pop = 1'b1; end
            I_LDCT: r_load = 1'b1;
            I_LOOP: if (pass) stk_pop = 1'b1;
                    else Y = tos;
            I_CONT: Y = upc_q;
            // Two-way branch: pass exits the loop, fail either iterates or leaves via D.
            I_TWB:  if (pass) stk_pop = 1'b1;
                    else if (!r_zero) begin Y = tos; r_dec = 1'b1; end
                    else begin Y = D; stk_pop = 1'b1; end
        endcase
    end

    // An external RLD_N load wins over both instruction loads and decrements.
    always_comb begin
        r_d = r_q;
        if (!RLD_N || r_load)
            r_d = D;
        else if (r_dec && !r_zero)
            r_d = r_q - ADDR_W'(1);
    end

    assign upc_d = Y + ADDR_W'(CI);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            upc_q <= '0;
            r_q   <= '0;
        end else begin
            upc_q <= upc_d;
            r_q   <= r_d;
        end
    end

    mps_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clr_i    (stk_clr),
        .push_i   (stk_push),
        .pop_i    (stk_pop),
        .data_i   (upc_q),
        .tos_o    (tos),
        .full_n_o (FULL_N)
    );

endmodule
